// File: rtl/noc_pkg.sv
// rtl/noc_pkg.sv - shared mesh packet layout, kind codes and receiver FSM states
package noc_pkg;

    localparam int ADDR_W    = 4;
    localparam int PKT_W     = 15;
    localparam int NUM_VC    = 8;
    localparam int VC_W      = 3;
    localparam int KIND_W    = 2;

    localparam int SRC_LSB   = 0;
    localparam int DEST_LSB  = 4;
    localparam int VC_LSB    = 8;
    localparam int PTYPE_LSB = 11;
    localparam int KIND_LSB  = 13;

    localparam logic [KIND_W-1:0] KIND_INV  = 2'b00;
    localparam logic [KIND_W-1:0] KIND_BODY = 2'b01;
    localparam logic [KIND_W-1:0] KIND_HEAD = 2'b10;
    localparam logic [KIND_W-1:0] KIND_TAIL = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_HALT = 2'd2
    } state_t;

    function automatic logic [VC_W-1:0] pkt_vc(input logic [PKT_W-1:0] pkt);
        return pkt[VC_LSB +: VC_W];
    endfunction

endpackage

// File: rtl/recv_fifo.sv
// rtl/recv_fifo.sv - DEPTH x W synchronous FIFO with full/empty/occupancy
module recv_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 15
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       wr_en,
    input  logic [W-1:0]               wdata,
    input  logic                       rd_en,
    output logic [W-1:0]               rdata,
    output logic                       full,
    output logic                       empty,
    output logic [$clog2(DEPTH):0]     count
);
    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  mem_q [DEPTH];
    logic [AW-1:0] wr_ptr_q, rd_ptr_q;
    logic [AW:0]   count_q;

    // Callers gate wr_en with !full and rd_en with !empty; power-of-two DEPTH lets pointers wrap naturally.
    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= wdata;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            if (wr_en) wr_ptr_q <= wr_ptr_q + AW'(1);
            if (rd_en) rd_ptr_q <= rd_ptr_q + AW'(1);
            case ({wr_en, rd_en})
                2'b10:   count_q <= count_q + (AW+1)'(1);
                2'b01:   count_q <= count_q - (AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    assign rdata = mem_q[rd_ptr_q];
    assign full  = (count_q == (AW+1)'(DEPTH));
    assign empty = (count_q == '0);
    assign count = count_q;

endmodule

// File: rtl/node_recv.sv
// rtl/node_recv.sv - mesh node ejection endpoint: FIFO, dest check, VC credits, counters
// Optional per-source statistics enabled by defining NODE_RECV_STATS_EN.
module node_recv
    import noc_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int CNT_W = 16
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [ADDR_W-1:0] node_addr,
    input  logic [PKT_W-1:0]  p,
    input  logic              p_valid,
    output logic              p_ready,
    output logic [NUM_VC-1:0] credit,
    input  logic              deq,
    output logic [PKT_W-1:0]  out_pkt,
    output logic              out_valid,
    output logic [CNT_W-1:0]  rx_cnt,
    output logic [CNT_W-1:0]  err_cnt,
    output logic              err_flag,
    input  logic              halt_on_err,
    input  logic [3:0]        stat_sel,
    output logic [CNT_W-1:0]  stat_cnt
);
    localparam int AW = $clog2(DEPTH);

    state_t            state_q, state_d;
    logic              accept, pop, pkt_err;
    logic              full, empty;
    logic [AW:0]       count;
    logic [PKT_W-1:0]  head;
    logic [NUM_VC-1:0] credit_q;
    logic [CNT_W-1:0]  rx_cnt_q, err_cnt_q;
    logic              err_flag_q;

    recv_fifo #(.DEPTH(DEPTH), .W(PKT_W)) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .wr_en (accept),
        .wdata (p),
        .rd_en (pop),
        .rdata (head),
        .full  (full),
        .empty (empty),
        .count (count)
    );

    // Ready is full-based only: a pop in the same cycle does not open a slot.
    assign p_ready   = !rst && !full && (state_q != ST_HALT);
    assign accept    = p_valid && p_ready;
    assign pop       = deq && !empty;
    assign pkt_err   = (p[DEST_LSB +: ADDR_W] != node_addr) || (p[KIND_LSB +: KIND_W] == KIND_INV);
    assign out_valid = !empty;
    assign out_pkt   = head;

    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (accept) state_d = ST_RUN;
            ST_RUN:  if (pop && !accept && count == (AW+1)'(1)) state_d = ST_IDLE;
            default: state_d = state_q;
        endcase
        if (accept && pkt_err && halt_on_err) state_d = ST_HALT;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            credit_q   <= '0;
            rx_cnt_q   <= '0;
            err_cnt_q  <= '0;
            err_flag_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            credit_q <= '0;
            if (pop) credit_q[pkt_vc(head)] <= 1'b1;
            if (accept) begin
                if (pkt_err) begin
                    if (err_cnt_q != '1) err_cnt_q <= err_cnt_q + CNT_W'(1);
                    err_flag_q <= 1'b1;
                end else if (rx_cnt_q != '1) begin
                    rx_cnt_q <= rx_cnt_q + CNT_W'(1);
                end
            end
        end
    end

    assign credit   = credit_q;
    assign rx_cnt   = rx_cnt_q;
    assign err_cnt  = err_cnt_q;
    assign err_flag = err_flag_q;

`ifdef NODE_RECV_STATS_EN
    logic [CNT_W-1:0] src_cnt_q [16];
    logic [CNT_W-1:0] stat_cnt_q;
    logic [3:0]       acc_src;

    assign acc_src = p[SRC_LSB +: ADDR_W];

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < 16; i++) src_cnt_q[i] <= '0;
            stat_cnt_q <= '0;
        end else begin
            if (accept && src_cnt_q[acc_src] != '1)
                src_cnt_q[acc_src] <= src_cnt_q[acc_src] + CNT_W'(1);
            stat_cnt_q <= src_cnt_q[stat_sel];
        end
    end

    assign stat_cnt = stat_cnt_q;
`else
    logic unused_stat;
    assign unused_stat = ^stat_sel;
    assign stat_cnt    = '0;
`endif

endmodule

// File: tb/tb_node_recv.sv
// tb/tb_node_recv.sv - self-checking bench for node_recv against a queue-based reference model
module tb_node_recv;
    localparam int DEPTH = 4;
    localparam int CNT_W = 16;

    logic             clk = 1'b0;
    logic             rst = 1'b1;
    logic [3:0]       node_addr = 4'h5;
    logic [14:0]      p = '0;
    logic             p_valid = 1'b0;
    logic             p_ready;
    logic [7:0]       credit;
    logic             deq = 1'b0;
    logic [14:0]      out_pkt;
    logic             out_valid;
    logic [CNT_W-1:0] rx_cnt, err_cnt, stat_cnt;
    logic             err_flag;
    logic             halt_on_err = 1'b0;
    logic [3:0]       stat_sel = '0;

    always #5 clk = ~clk;

    node_recv #(.DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
        .clk(clk), .rst(rst), .node_addr(node_addr), .p(p), .p_valid(p_valid),
        .p_ready(p_ready), .credit(credit), .deq(deq), .out_pkt(out_pkt),
        .out_valid(out_valid), .rx_cnt(rx_cnt), .err_cnt(err_cnt), .err_flag(err_flag),
        .halt_on_err(halt_on_err), .stat_sel(stat_sel), .stat_cnt(stat_cnt)
    );

    int n_checks = 0;
    int n_fail   = 0;

    logic [14:0] mq[$];
    int          m_rx, m_err;
    bit          m_flag, m_halt;
    logic [7:0]  m_credit;
    int          m_src[16];

    function automatic logic [14:0] mk(int src, int dest, int vc, int ptype, int kind);
        return {kind[1:0], ptype[1:0], vc[2:0], dest[3:0], src[3:0]};
    endfunction

    // Advance one clock, updating the reference model from the inputs presented this cycle.
    task automatic tick();
        bit ready, acc, pop;
        logic [14:0] pk;
        ready = !rst && (mq.size() < DEPTH) && !m_halt;
        acc   = p_valid && ready;
        pop   = !rst && deq && (mq.size() > 0);
        pk    = p;
        @(posedge clk);
        if (rst) begin
            mq.delete();
            m_rx = 0; m_err = 0; m_flag = 0; m_halt = 0; m_credit = '0;
            foreach (m_src[i]) m_src[i] = 0;
        end else begin
            m_credit = pop ? (8'd1 << mq[0][10:8]) : 8'd0;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(pk);
                m_src[pk[3:0]]++;
                if (pk[7:4] == node_addr && pk[14:13] != 2'b00) m_rx++;
                else begin
                    m_err++;
                    m_flag = 1;
                    if (halt_on_err) m_halt = 1;
                end
            end
        end
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst = 1'b1;
        repeat (2) tick();
        n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL reset_p_ready got=%b exp=0", p_ready); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        n_checks++; if (credit !== 8'h00) begin n_fail++; $display("FAIL reset_credit got=%h exp=00", credit); end
        n_checks++; if (rx_cnt !== '0 || err_cnt !== '0) begin n_fail++; $display("FAIL reset_counters got rx=%0d err=%0d exp=0", rx_cnt, err_cnt); end
        n_checks++; if (err_flag !== 1'b0) begin n_fail++; $display("FAIL reset_err_flag got=%b exp=0", err_flag); end
        n_checks++; if (stat_cnt !== '0) begin n_fail++; $display("FAIL reset_stat_cnt got=%0d exp=0", stat_cnt); end
        rst = 1'b0;
        tick();
        n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL post_reset_p_ready got=%b exp=1", p_ready); end
    endtask

    task automatic test_single();
        logic [14:0] pk;
        pk = mk(3, 5, 2, 0, 2);
        node_addr = 4'h5; p = pk; p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL single_out_valid got=%b exp=1", out_valid); end
        n_checks++; if (out_pkt !== pk) begin n_fail++; $display("FAIL single_out_pkt got=%h exp=%h", out_pkt, pk); end
        n_checks++; if (rx_cnt !== 16'd1 || err_cnt !== 16'd0) begin n_fail++; $display("FAIL single_counts got rx=%0d err=%0d exp rx=1 err=0", rx_cnt, err_cnt); end
        deq = 1'b1;
        tick();
        deq = 1'b0;
        n_checks++; if (credit !== 8'h04) begin n_fail++; $display("FAIL single_credit got=%h exp=04", credit); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL single_drained got=%b exp=0", out_valid); end
        tick();
        n_checks++; if (credit !== 8'h00) begin n_fail++; $display("FAIL single_credit_width got=%h exp=00", credit); end
    endtask

    task automatic test_fill();
        for (int i = 0; i < 4; i++) begin
            p = mk(i, 5, i + 4, 1, 1); p_valid = 1'b1;
            tick();
        end
        n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL fill_full_p_ready got=%b exp=0", p_ready); end
        p = mk(9, 5, 0, 0, 3);
        tick();
        p_valid = 1'b0;
        n_checks++; if (rx_cnt !== 16'd5) begin n_fail++; $display("FAIL fill_rx_cnt got=%0d exp=5", rx_cnt); end
        n_checks++; if (out_pkt !== mk(0, 5, 4, 1, 1)) begin n_fail++; $display("FAIL fill_head got=%h exp=%h", out_pkt, mk(0, 5, 4, 1, 1)); end
        deq = 1'b1;
        tick();
        deq = 1'b0;
        n_checks++; if (credit !== 8'h10) begin n_fail++; $display("FAIL fill_credit got=%h exp=10", credit); end
        n_checks++; if (p_ready !== 1'b1) begin n_fail++; $display("FAIL fill_ready_after_pop got=%b exp=1", p_ready); end
        deq = 1'b1;
        repeat (3) tick();
        deq = 1'b0;
        n_checks++; if (credit !== 8'h80) begin n_fail++; $display("FAIL fill_last_credit got=%h exp=80", credit); end
        n_checks++; if (out_valid !== 1'b0) begin n_fail++; $display("FAIL fill_fifth_dropped got=%b exp=0", out_valid); end
    endtask

    task automatic test_error();
        halt_on_err = 1'b0;
        p = mk(1, 9, 6, 0, 2); p_valid = 1'b1;
        tick();
        p_valid = 1'b0;
        n_checks++; if (err_cnt !== 16'd1 || err_flag !== 1'b1) begin n_fail++; $display("FAIL err_dest got err=%0d flag=%b exp err=1 flag=1", err_cnt, err_flag); end
        n_checks++; if (rx_cnt !== 16'd5) begin n_fail++; $display("FAIL err_rx_unchanged got=%0d exp=5", rx_cnt); end
        n_checks++; if (out_valid !== 1'b1 || p_ready !== 1'b1) begin n_fail++; $display("FAIL err_enqueued got valid=%b ready=%b exp 1/1", out_valid, p_ready); end
        deq = 1'b1;
        tick();
        deq = 1'b0;
        n_checks++; if (credit !== 8'h40) begin n_fail++; $display("FAIL err_credit got=%h exp=40", credit); end
        p = mk(2, 5, 1, 0, 0); p_valid = 1'b1;
        tick();
        p_valid = 1'b0; deq = 1'b1;
        tick();
        deq = 1'b0;
        n_checks++; if (err_cnt !== 16'd2 || rx_cnt !== 16'd5) begin n_fail++; $display("FAIL err_kind_inv got err=%0d rx=%0d exp err=2 rx=5", err_cnt, rx_cnt); end
        n_checks++; if (credit !== 8'h02) begin n_fail++; $display("FAIL err_kind_credit got=%h exp=02", credit); end
    endtask

    task automatic test_halt();
        logic [7:0] exp_cr[3];
        exp_cr[0] = 8'h01; exp_cr[1] = 8'h08; exp_cr[2] = 8'h20;
        p_valid = 1'b1;
        p = mk(3, 5, 0, 0, 2); tick();
        p = mk(3, 5, 3, 0, 3); tick();
        halt_on_err = 1'b1;
        p = mk(3, 4, 5, 0, 2); tick();
        halt_on_err = 1'b0;
        n_checks++; if (p_ready !== 1'b0) begin n_fail++; $display("FAIL halt_p_ready got=%b exp=0", p_ready); end
        n_checks++; if (err_cnt !== 16'd3) begin n_fail++; $display("FAIL halt_err_cnt got=%0d exp=3", err_cnt); end
        p = mk(4, 5, 7, 0, 2); deq = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_checks++; if (credit !== exp_cr[i]) begin n_fail++; $display("FAIL halt_drain_credit%0d got=%h exp=%h", i, credit, exp_cr[i]); end
        end
        p_valid = 1'b0; deq = 1'b0;
        tick();
        n_checks++; if (out_valid !== 1'b0 || p_ready !== 1'b0) begin n_fail++; $display("FAIL halt_sticky got valid=%b ready=%b exp 0/0", out_valid, p_ready); end
        n_checks++; if (rx_cnt !== 16'd7) begin n_fail++; $display("FAIL halt_rx_cnt got=%0d exp=7", rx_cnt); end
    endtask

    task automatic test_rst_mid();
        rst = 1'b1; tick(); rst = 1'b0;
        p_valid = 1'b1;
        for (int i = 0; i < 3; i++) begin p = mk(i, 5, i, 0, 1); tick(); end
        p_valid = 1'b0;
        n_checks++; if (out_valid !== 1'b1) begin n_fail++; $display("FAIL rstmid_loaded got=%b exp=1", out_valid); end
        rst = 1'b1; deq = 1'b1;
        tick();
        rst = 1'b0;
        n_checks++; if (out_valid !== 1'b0 || credit !== 8'h00) begin n_fail++; $display("FAIL rstmid_flush got valid=%b credit=%h exp 0/00", out_valid, credit); end
        n_checks++; if (rx_cnt !== '0 || err_cnt !== '0 || err_flag !== 1'b0) begin n_fail++; $display("FAIL rstmid_counters got rx=%0d err=%0d flag=%b exp 0", rx_cnt, err_cnt, err_flag); end
        tick();
        deq = 1'b0;
        n_checks++; if (credit !== 8'h00 || p_ready !== 1'b1) begin n_fail++; $display("FAIL rstmid_after got credit=%h ready=%b exp 00/1", credit, p_ready); end
    endtask

    task automatic test_random();
        int iters;
        iters = 0;
        rst = 1'b1; tick(); rst = 1'b0;
        node_addr = 4'($urandom_range(0, 15));
        repeat (600) begin
            iters++;
            rst         = ($urandom_range(0, 99) == 0);
            halt_on_err = ($urandom_range(0, 49) == 0);
            p_valid     = ($urandom_range(0, 9) < 6);
            deq         = ($urandom_range(0, 1) == 1);
            p = mk($urandom_range(0, 15),
                   ($urandom_range(0, 9) < 8) ? int'(node_addr) : int'($urandom_range(0, 15)),
                   $urandom_range(0, 7), $urandom_range(0, 3),
                   ($urandom_range(0, 9) < 9) ? int'($urandom_range(1, 3)) : 0);
            tick();
            n_checks++; if (p_ready !== (!rst && mq.size() < DEPTH && !m_halt)) begin n_fail++; $display("FAIL rand_p_ready it=%0d got=%b exp=%b", iters, p_ready, (!rst && mq.size() < DEPTH && !m_halt)); end
            n_checks++; if (out_valid !== (mq.size() > 0)) begin n_fail++; $display("FAIL rand_out_valid it=%0d got=%b exp=%b", iters, out_valid, (mq.size() > 0)); end
            if (mq.size() > 0) begin
                n_checks++; if (out_pkt !== mq[0]) begin n_fail++; $display("FAIL rand_out_pkt it=%0d got=%h exp=%h", iters, out_pkt, mq[0]); end
            end
            n_checks++; if (credit !== m_credit) begin n_fail++; $display("FAIL rand_credit it=%0d got=%h exp=%h", iters, credit, m_credit); end
            n_checks++; if (rx_cnt !== CNT_W'(m_rx) || err_cnt !== CNT_W'(m_err) || err_flag !== m_flag) begin
                n_fail++; $display("FAIL rand_counters it=%0d got rx=%0d err=%0d flag=%b exp rx=%0d err=%0d flag=%b", iters, rx_cnt, err_cnt, err_flag, m_rx, m_err, m_flag);
            end
        end
        rst = 1'b0; p_valid = 1'b0; deq = 1'b0; halt_on_err = 1'b0;
    endtask

    task automatic test_stats();
        int exp3, exp7;
        rst = 1'b1; tick(); rst = 1'b0;
        node_addr = 4'h5; p_valid = 1'b1; deq = 1'b1;
        for (int i = 0; i < 7; i++) begin
            p = mk((i < 5) ? 3 : 7, 5, i, 0, 2);
            tick();
        end
        p_valid = 1'b0; deq = 1'b0;
`ifdef NODE_RECV_STATS_EN
        exp3 = 5; exp7 = 2;
`else
        exp3 = 0; exp7 = 0;
`endif
        stat_sel = 4'd3; repeat (2) tick();
        n_checks++; if (stat_cnt !== CNT_W'(exp3)) begin n_fail++; $display("FAIL stats_src3 got=%0d exp=%0d", stat_cnt, exp3); end
        stat_sel = 4'd7; repeat (2) tick();
        n_checks++; if (stat_cnt !== CNT_W'(exp7)) begin n_fail++; $display("FAIL stats_src7 got=%0d exp=%0d", stat_cnt, exp7); end
        n_checks++; if (rx_cnt !== CNT_W'(m_rx)) begin n_fail++; $display("FAIL stats_rx_cnt got=%0d exp=%0d", rx_cnt, m_rx); end
    endtask

    initial begin
        test_reset();
        test_single();
        test_fill();
        test_error();
        test_halt();
        test_rst_mid();
        test_random();
        test_stats();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
